ili9341_seq: RTL



---
 rtl/ili9341_pkg.sv | 36 +++
 rtl/ili9341_delay_cnt.sv | 23 ++
 rtl/ili9341_seq.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ili9341_pkg.sv
// Shared constants, init command ROM and state encoding for the ILI9341 sequencer.
package ili9341_pkg;

  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] COLMOD  = 8'h3A;
  localparam logic [7:0] MADCTL  = 8'h36;
  localparam logic [7:0] DISPON  = 8'h29;
  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] PASET   = 8'h2B;
  localparam logic [7:0] RAMWR   = 8'h2C;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
    logic       dly;
  } init_entry_t;

  localparam int unsigned INIT_LEN = 7;

  // dly marks entries the panel needs settling time after.
  localparam init_entry_t INIT_ROM [INIT_LEN] = '{
    '{dc: 1'b0, data: SWRESET, dly: 1'b1},
    '{dc: 1'b0, data: SLPOUT,  dly: 1'b1},
    '{dc: 1'b0, data: COLMOD,  dly: 1'b0},
    '{dc: 1'b1, data: 8'h55,   dly: 1'b0},
    '{dc: 1'b0, data: MADCTL,  dly: 1'b0},
    '{dc: 1'b1, data: 8'h48,   dly: 1'b0},
    '{dc: 1'b0, data: DISPON,  dly: 1'b0}
  };

  typedef enum logic [2:0] {
    HWRST, HWWAIT, INIT, IWAIT, IDLE, WIN, PIXHI, PIXLO
  } state_t;

endpackage

// File: rtl/ili9341_delay_cnt.sv
// Up-counter shared by the reset pulse, reset wait and post-command waits.
module ili9341_delay_cnt #(
  parameter int unsigned CW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] limit,
  output logic          done_c
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (load) cnt <= '0;
    else if (en)   cnt <= cnt + CW'(1);
  end

  assign done_c = (cnt == limit - CW'(1));

endmodule

// File: rtl/ili9341_seq.sv
// ILI9341 command/data sequencer: hardware reset, init list, then full-frame
// redraws whenever visua changes, over a valid/ready byte handshake.
module ili9341_seq
  import ili9341_pkg::*;
#(
  parameter int unsigned WIDTH         = 240,
  parameter int unsigned HEIGHT        = 320,
  parameter int unsigned RST_PULSE_CYC = 1000,
  parameter int unsigned RST_WAIT_CYC  = 5000,
  parameter int unsigned CMD_WAIT_CYC  = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  visua,
  output logic        lcd_rst_n,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  input  logic        tx_ready,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  input  logic [15:0] pix_rgb565,
  output logic [2:0]  frame_visua,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned MAX_A   = (RST_PULSE_CYC > RST_WAIT_CYC) ? RST_PULSE_CYC : RST_WAIT_CYC;
  localparam int unsigned MAX_DLY = (MAX_A > CMD_WAIT_CYC) ? MAX_A : CMD_WAIT_CYC;
  localparam int unsigned CW      = $clog2(MAX_DLY + 1);
  localparam logic [8:0]  X_LAST  = 9'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST  = 9'(HEIGHT - 1);
  localparam logic [15:0] W_END   = 16'(WIDTH - 1);
  localparam logic [15:0] H_END   = 16'(HEIGHT - 1);

  function automatic logic [7:0] win_byte(input logic [3:0] i);
    case (i)
      4'd0:    win_byte = CASET;
      4'd3:    win_byte = W_END[15:8];
      4'd4:    win_byte = W_END[7:0];
      4'd5:    win_byte = PASET;
      4'd8:    win_byte = H_END[15:8];
      4'd9:    win_byte = H_END[7:0];
      4'd10:   win_byte = RAMWR;
      default: win_byte = 8'h00;
    endcase
  endfunction

  state_t        state, state_d;
  logic [2:0]    idx, idx_d, idx_nx;
  logic [3:0]    win_i, win_i_d, win_nx;
  logic [8:0]    pix_x_d, pix_y_d;
  logic          pending, pending_d;
  logic [2:0]    frame_visua_d;
  logic          tx_valid_d, tx_dc_d;
  logic [7:0]    tx_byte, tx_byte_d;
  logic          lcd_rst_n_d, frame_done_d;
  logic          cnt_load, cnt_en, dly_done;
  logic [CW-1:0] cnt_limit;
  logic          xfer;

  assign xfer   = tx_valid && tx_ready;
  assign idx_nx = idx + 3'd1;
  assign win_nx = win_i + 4'd1;

  // Colour passes straight through; the generator is combinational on pix_x/pix_y.
  assign tx_data = (state == PIXHI) ? pix_rgb565[15:8] :
                   (state == PIXLO) ? pix_rgb565[7:0]  : tx_byte;

  ili9341_delay_cnt #(.CW(CW)) u_dly (
    .clk    (clk),
    .rst    (rst),
    .load   (cnt_load),
    .en     (cnt_en),
    .limit  (cnt_limit),
    .done_c (dly_done)
  );

  always_comb begin
    state_d       = state;
    idx_d         = idx;
    win_i_d       = win_i;
    pix_x_d       = pix_x;
    pix_y_d       = pix_y;
    pending_d     = pending;
    frame_visua_d = frame_visua;
    tx_valid_d    = tx_valid;
    tx_byte_d     = tx_byte;
    tx_dc_d       = tx_dc;
    lcd_rst_n_d   = lcd_rst_n;
    frame_done_d  = 1'b0;
    cnt_load      = 1'b0;
    cnt_en        = 1'b0;
    cnt_limit     = CW'(RST_PULSE_CYC);
    case (state)
      HWRST: begin
        cnt_en      = 1'b1;
        lcd_rst_n_d = 1'b0;
        if (dly_done) begin
          state_d     = HWWAIT;
          cnt_load    = 1'b1;
          lcd_rst_n_d = 1'b1;
        end
      end
      HWWAIT: begin
        cnt_en    = 1'b1;
        cnt_limit = CW'(RST_WAIT_CYC);
        if (dly_done) begin
          state_d    = INIT;
          cnt_load   = 1'b1;
          idx_d      = 3'd0;
          tx_valid_d = 1'b1;
          tx_byte_d  = INIT_ROM[0].data;
          tx_dc_d    = INIT_ROM[0].dc;
        end
      end
      INIT: begin
        if (xfer) begin
          if (INIT_ROM[idx].dly) begin
            state_d    = IWAIT;
            tx_valid_d = 1'b0;
            cnt_load   = 1'b1;
          end else if (idx == 3'(INIT_LEN - 1)) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            pending_d  = 1'b1;
          end else begin
            idx_d     = idx_nx;
            tx_byte_d = INIT_ROM[idx_nx].data;
            tx_dc_d   = INIT_ROM[idx_nx].dc;
          end
        end
      end
      IWAIT: begin
        cnt_en    = 1'b1;
        cnt_limit = CW'(CMD_WAIT_CYC);
        if (dly_done) begin
          state_d    = INIT;
          cnt_load   = 1'b1;
          idx_d      = idx_nx;
          tx_valid_d = 1'b1;
          tx_byte_d  = INIT_ROM[idx_nx].data;
          tx_dc_d    = INIT_ROM[idx_nx].dc;
        end
      end
      IDLE: begin
        if (pending || (visua != frame_visua)) begin
          state_d       = WIN;
          frame_visua_d = visua;
          pending_d     = 1'b0;
          win_i_d       = 4'd0;
          tx_valid_d    = 1'b1;
          tx_byte_d     = win_byte(4'd0);
          tx_dc_d       = 1'b0;
        end
      end
      WIN: begin
        if (xfer) begin
          if (win_i == 4'd10) begin
            state_d = PIXHI;
            pix_x_d = 9'd0;
            pix_y_d = 9'd0;
            tx_dc_d = 1'b1;
          end else begin
            win_i_d   = win_nx;
            tx_byte_d = win_byte(win_nx);
            tx_dc_d   = (win_nx != 4'd5) && (win_nx != 4'd10);
          end
        end
      end
      PIXHI: begin
        if (xfer) state_d = PIXLO;
      end
      PIXLO: begin
        if (xfer) begin
          if ((pix_x == X_LAST) && (pix_y == Y_LAST)) begin
            state_d      = IDLE;
            tx_valid_d   = 1'b0;
            frame_done_d = 1'b1;
          end else if (pix_x == X_LAST) begin
            state_d = PIXHI;
            pix_x_d = 9'd0;
            pix_y_d = pix_y + 9'd1;
          end else begin
            state_d = PIXHI;
            pix_x_d = pix_x + 9'd1;
          end
        end
      end
      default: state_d = HWRST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HWRST;
      idx         <= 3'd0;
      win_i       <= 4'd0;
      pix_x       <= 9'd0;
      pix_y       <= 9'd0;
      pending     <= 1'b0;
      frame_visua <= 3'd0;
      tx_valid    <= 1'b0;
      tx_byte     <= 8'h00;
      tx_dc       <= 1'b0;
      lcd_rst_n   <= 1'b0;
      busy        <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      win_i       <= win_i_d;
      pix_x       <= pix_x_d;
      pix_y       <= pix_y_d;
      pending     <= pending_d;
      frame_visua <= frame_visua_d;
      tx_valid    <= tx_valid_d;
      tx_byte     <= tx_byte_d;
      tx_dc       <= tx_dc_d;
      lcd_rst_n   <= lcd_rst_n_d;
      busy        <= (state_d != IDLE);
      frame_done  <= frame_done_d;
    end
  end

endmodule
